// File: rtl/bin_to_bcd_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bin_to_bcd_seq_if : request / result bundle of the BCD converter     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface bin_to_bcd_seq_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic [WIDTH-1:0]    bin_in;
  logic                in_valid;
  logic                in_ready;
  logic [4*DIGITS-1:0] bcd_out;
  logic                out_valid;
  logic                busy;

  modport master (
    output bin_in, in_valid,
    input  in_ready, bcd_out, out_valid, busy
  );

  modport slave (
    input  bin_in, in_valid,
    output in_ready, bcd_out, out_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bin_to_bcd_seq : one-bit-per-clock double-dabble binary to BCD       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bin_to_bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  wire logic        clk,
  input  wire logic        rstn,
  bin_to_bcd_seq_if.slave  bus
);

  localparam int c_BCD_W = 4 * DIGITS;
  localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_next;
  logic               w_in_ready;
  logic               w_busy;
  logic               w_load;
  logic               w_last;

  logic [WIDTH-1:0]   r_bin;
  logic [c_BCD_W-1:0] r_scratch;
  logic [c_BCD_W-1:0] w_adj;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_BCD_W-1:0] r_bcd;
  logic               r_out_valid;

  assign w_last = (r_cnt == '0);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid) w_next = S_SHIFT;
      S_SHIFT: if (w_last)       w_next = S_DONE;
      S_DONE:                    w_next = S_IDLE;
      default:                   w_next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    w_in_ready = 1'b0;
    w_busy     = 1'b1;
    w_load     = 1'b0;
    if (r_state == S_IDLE) begin
      w_in_ready = 1'b1;
      w_busy     = 1'b0;
      w_load     = bus.in_valid;
    end
  end

  // Add-3 correction on pre-shift digits; a digit tops out at 12, so no carry
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    assign w_adj[4*k +: 4] = (r_scratch[4*k +: 4] >= 4'd5) ? r_scratch[4*k +: 4] + 4'd3
                                                           : r_scratch[4*k +: 4];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bin       <= '0;
      r_scratch   <= '0;
      r_cnt       <= '0;
      r_bcd       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= (r_state == S_DONE);
      if (w_load) begin
        r_bin     <= bus.bin_in;
        r_scratch <= '0;
        r_cnt     <= c_CNT_W'(WIDTH - 1);
      end else if (r_state == S_SHIFT) begin
        // Top digit's MSB is always zero when 10^DIGITS covers the input range
        r_scratch <= c_BCD_W'({w_adj, r_bin[WIDTH-1]});
        r_bin     <= {r_bin[WIDTH-2:0], 1'b0};
        r_cnt     <= r_cnt - c_CNT_W'(1);
      end
      if (r_state == S_DONE) r_bcd <= r_scratch;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.busy      = w_busy;
  assign bus.bcd_out   = r_bcd;
  assign bus.out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bin_to_bcd_seq : self-checking bench for bin_to_bcd_seq           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.WIDTH(16), .DIGITS(5)) bus ();

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic [15:0] bin;
    logic [19:0] exp;
  } vec_t;

  int n_checks   = 0;
  int n_pass     = 0;
  int n_acc      = 0;
  int n_pulse    = 0;
  int n_unstable = 0;
  logic [19:0] prev_bcd = '0;

  logic [19:0] s_res [3];
  int          s_t   [3];
  int          s_np;

  always @(posedge clk)
    if (rstn && bus.in_valid && bus.in_ready) n_acc++;

  always @(negedge clk) begin
    if (rstn) begin
      if (bus.out_valid === 1'b1) n_pulse++;
      else if (bus.bcd_out !== prev_bcd) n_unstable++;
    end
    prev_bcd = bus.bcd_out;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // Reference: decimal digits by plain division
  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned p;
    r = '0;
    p = 1;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // lat counts clock edges after the accept edge until out_valid is seen
  task automatic convert(input logic [15:0] v, output logic [19:0] res,
                         output int lat, output int ready_bad);
    int w;
    ready_bad = 0;
    lat       = 0;
    @(negedge clk);
    bus.bin_in   = v;
    bus.in_valid = 1'b1;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.bin_in   = 16'($urandom);
    if (bus.in_ready !== 1'b0) ready_bad++;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid === 1'b1) break;
      if (bus.in_ready !== 1'b0) ready_bad++;
    end
    res = bus.bcd_out;
  endtask

  // in_valid held high; bin_in advances right after each accept
  task automatic stream(input logic [15:0] v0, input logic [15:0] v1,
                        input logic [15:0] v2, input int n);
    int   idx, cyc, np;
    logic pr;
    idx = 0; cyc = 0; np = 0;
    @(negedge clk);
    bus.bin_in   = v0;
    bus.in_valid = 1'b1;
    while (np < n && cyc < 200) begin
      pr = bus.in_ready;
      @(negedge clk);
      cyc++;
      if (pr && bus.in_valid) begin
        idx++;
        if (idx < n) bus.bin_in = (idx == 1) ? v1 : v2;
        else         bus.in_valid = 1'b0;
      end
      if (bus.out_valid === 1'b1) begin
        s_res[np] = bus.bcd_out;
        s_t[np]   = cyc;
        np++;
      end
    end
    s_np = np;
  endtask

  initial begin
    vec_t        tbl [8];
    logic [19:0] res;
    int          lat, rb, pulses_before;
    logic [15:0] v;

    tbl[0] = '{16'd0,     20'h00000};
    tbl[1] = '{16'd65535, 20'h65535};
    tbl[2] = '{16'd9999,  20'h09999};
    tbl[3] = '{16'd1,     20'h00001};
    tbl[4] = '{16'd5,     20'h00005};
    tbl[5] = '{16'd10000, 20'h10000};
    tbl[6] = '{16'd59999, 20'h59999};
    tbl[7] = '{16'd4096,  20'h04096};

    rstn         = 1'b0;
    bus.in_valid = 1'b0;
    bus.bin_in   = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_busy",      bus.busy,      0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_bcd_out",   bus.bcd_out,   0);
    rstn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      convert(tbl[i].bin, res, lat, rb);
      check("tbl_bcd",           res,          tbl[i].exp);
      check("tbl_latency",       lat,          17);
      check("tbl_ready_low",     rb,           0);
      check("tbl_ready_at_done", bus.in_ready, 1);
      @(negedge clk);
      check("tbl_pulse_one_cycle", bus.out_valid, 0);
      check("tbl_bcd_held",        bus.bcd_out,   tbl[i].exp);
    end

    stream(16'd1234, 16'd4321, 16'd0, 2);
    check("hold_pulses",   s_np,              2);
    check("hold_first",    s_res[0],          20'h01234);
    check("hold_second",   s_res[1],          20'h04321);
    check("hold_first_t",  s_t[0],            18);
    check("hold_spacing",  s_t[1] - s_t[0],   18);

    stream(16'd7, 16'd10, 16'd100, 3);
    check("b2b_pulses",    s_np,              3);
    check("b2b_res0",      s_res[0],          20'h00007);
    check("b2b_res1",      s_res[1],          20'h00010);
    check("b2b_res2",      s_res[2],          20'h00100);
    check("b2b_gap0",      s_t[1] - s_t[0],   18);
    check("b2b_gap1",      s_t[2] - s_t[1],   18);

    // Abort mid-conversion
    @(negedge clk);
    bus.bin_in   = 16'd4096;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    pulses_before = n_pulse;
    rstn = 1'b0;
    #1;
    check("abort_in_ready",  bus.in_ready,  1);
    check("abort_busy",      bus.busy,      0);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_bcd_out",   bus.bcd_out,   0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (25) @(negedge clk);
    check("abort_no_pulse", n_pulse, pulses_before);
    convert(16'd42, res, lat, rb);
    check("after_abort_bcd",     res, 20'h00042);
    check("after_abort_latency", lat, 17);

    for (int i = 0; i < 1000; i++) begin
      v = 16'($urandom);
      convert(v, res, lat, rb);
      check("rand_bcd", res, ref_bcd(v));
    end

    repeat (2) @(negedge clk);
    check("pulse_vs_accept", n_pulse, n_acc - 1);
    check("bcd_stable",      n_unstable, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
